// File: rtl/riscv_register_file_sb.sv
// Parametrised integer/FP register file with per-register tags and a busy scoreboard.
// A destination is reserved at issue and cleared by any write to it at writeback.
// Optional feature macro: RISCV_RF_BYPASS_EN forwards same-cycle writes to the read ports.
// Storage is one flat array. When the FP bank exists it occupies the upper half, so the
// address MSB acts as the bank select for reads, writes and the scoreboard.
module riscv_register_file_sb #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 1,
  parameter int unsigned N_READ     = 3,
  parameter int unsigned N_WRITE    = 2,
  parameter int unsigned FPU        = 0,
  parameter int unsigned Zfinx      = 0,
  localparam int unsigned RA_W      = ADDR_WIDTH + ((FPU != 0 && Zfinx == 0) ? 1 : 0)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_READ*RA_W-1:0]          raddr_i,
  output logic [N_READ*DATA_WIDTH-1:0]    rdata_o,
  output logic [N_READ*TAG_WIDTH-1:0]     rtag_o,
  output logic [N_READ-1:0]               rbusy_o,
  input  logic [N_WRITE*RA_W-1:0]         waddr_i,
  input  logic [N_WRITE*DATA_WIDTH-1:0]   wdata_i,
  input  logic [N_WRITE*TAG_WIDTH-1:0]    wtag_i,
  input  logic [N_WRITE-1:0]              we_i,
  input  logic                            rsv_valid_i,
  input  logic [RA_W-1:0]                 rsv_addr_i,
  output logic                            rsv_ready_o,
  output logic [RA_W:0]                   busy_cnt_o
);

  localparam int unsigned NREG = 1 << RA_W;

  logic [DATA_WIDTH-1:0] mem_q  [NREG];
  logic [TAG_WIDTH-1:0]  tag_q  [NREG];
  logic [NREG-1:0]       busy_q, busy_d;
  logic [RA_W:0]         cnt_q, cnt_d;

  // Per-register write decode after port priority resolution
  logic                  wr_en   [NREG];
  logic [DATA_WIDTH-1:0] wr_data [NREG];
  logic [TAG_WIDTH-1:0]  wr_tag  [NREG];
  logic [RA_W-1:0]       wa;
  logic [RA_W-1:0]       ra;

  // Resolve write ports per register; later ports overwrite earlier ones, x0 is dropped
  always_comb begin
    wa = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      wr_en[i]   = 1'b0;
      wr_data[i] = '0;
      wr_tag[i]  = '0;
    end
    for (int unsigned p = 0; p < N_WRITE; p++) begin
      wa = waddr_i[p*RA_W +: RA_W];
      if (we_i[p] && wa != '0) begin
        wr_en[wa]   = 1'b1;
        wr_data[wa] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
        wr_tag[wa]  = wtag_i[p*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  // A busy register refuses reservations, so a same-cycle clear always wins on busy entries
  assign rsv_ready_o = rsv_valid_i & ~busy_q[rsv_addr_i];

  // Scoreboard next state: clear on write, then set on accepted reserve (set wins when idle)
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (wr_en[i]) busy_d[i] = 1'b0;
    end
    if (rsv_ready_o && rsv_addr_i != '0) busy_d[rsv_addr_i] = 1'b1;
    cnt_d = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_d = cnt_d + {{RA_W{1'b0}}, busy_d[i]};
    end
  end

  // State update; reset drops any in-flight writes and reservations
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (wr_en[i]) begin
          mem_q[i] <= wr_data[i];
          tag_q[i] <= wr_tag[i];
        end
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt_o = cnt_q;

  // Read ports; x0 is never written so it always reads zero and is never busy
  always_comb begin
    rdata_o = '0;
    rtag_o  = '0;
    rbusy_o = '0;
    ra      = '0;
    for (int unsigned k = 0; k < N_READ; k++) begin
      ra = raddr_i[k*RA_W +: RA_W];
`ifdef RISCV_RF_BYPASS_EN
      if (wr_en[ra]) begin
        rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = wr_data[ra];
        rtag_o[k*TAG_WIDTH +: TAG_WIDTH]    = wr_tag[ra];
        rbusy_o[k]                          = 1'b0;
      end else begin
        rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[ra];
        rtag_o[k*TAG_WIDTH +: TAG_WIDTH]    = tag_q[ra];
        rbusy_o[k]                          = busy_q[ra];
      end
`else
      rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[ra];
      rtag_o[k*TAG_WIDTH +: TAG_WIDTH]    = tag_q[ra];
      rbusy_o[k]                          = busy_q[ra];
`endif
    end
  end

endmodule

// File: tb/tb_riscv_register_file_sb.sv
// Directed bench for riscv_register_file_sb: vector table plus bypass and FP-bank sequences.
module tb_riscv_register_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] raddr;
  logic [95:0] rdata;
  logic [2:0]  rtag;
  logic [2:0]  rbusy;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  wtag;
  logic [1:0]  we;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        rsv_ready;
  logic [5:0]  busy_cnt;

  logic [17:0] fp_raddr;
  logic [95:0] fp_rdata;
  logic [2:0]  fp_rtag;
  logic [2:0]  fp_rbusy;
  logic [11:0] fp_waddr;
  logic [63:0] fp_wdata;
  logic [1:0]  fp_wtag;
  logic [1:0]  fp_we;
  logic        fp_rsv_valid;
  logic [5:0]  fp_rsv_addr;
  logic        fp_rsv_ready;
  logic [6:0]  fp_busy_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  riscv_register_file_sb dut (
    .clk         (clk),
    .rst         (rst),
    .raddr_i     (raddr),
    .rdata_o     (rdata),
    .rtag_o      (rtag),
    .rbusy_o     (rbusy),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
    .wtag_i      (wtag),
    .we_i        (we),
    .rsv_valid_i (rsv_valid),
    .rsv_addr_i  (rsv_addr),
    .rsv_ready_o (rsv_ready),
    .busy_cnt_o  (busy_cnt)
  );

  riscv_register_file_sb #(.FPU(1)) dut_fp (
    .clk         (clk),
    .rst         (rst),
    .raddr_i     (fp_raddr),
    .rdata_o     (fp_rdata),
    .rtag_o      (fp_rtag),
    .rbusy_o     (fp_rbusy),
    .waddr_i     (fp_waddr),
    .wdata_i     (fp_wdata),
    .wtag_i      (fp_wtag),
    .we_i        (fp_we),
    .rsv_valid_i (fp_rsv_valid),
    .rsv_addr_i  (fp_rsv_addr),
    .rsv_ready_o (fp_rsv_ready),
    .busy_cnt_o  (fp_busy_cnt)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        wt0, wt1;
    logic        rv;
    logic [4:0]  ra;
    logic [4:0]  r0, r1, r2;
    logic        chk;
    logic [31:0] e0, e1, e2;
    logic [2:0]  et, eb;
    logic        erdy;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; we = '0; waddr = '0; wdata = '0; wtag = '0;
    rsv_valid = 1'b0; rsv_addr = '0; raddr = '0;
    fp_we = '0; fp_waddr = '0; fp_wdata = '0; fp_wtag = '0;
    fp_rsv_valid = 1'b0; fp_rsv_addr = '0; fp_raddr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //        rst   we     wa0   wa1   wd0           wd1           wt0   wt1   rv    ra
    //        r0    r1     r2    chk   e0            e1            e2            et      eb      rdy   cnt
    vecs[0]  = '{1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0,
                 5'd5, 5'd7, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 1'b0, 6'd0};
    vecs[1]  = '{1'b0, 2'b11, 5'd5, 5'd5, 32'hAAAA_0000, 32'h5555_FFFF, 1'b0, 1'b1, 1'b0, 5'd0,
                 5'd1, 5'd7, 5'd9, 1'b1, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 1'b0, 6'd0};
    vecs[2]  = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7,
                 5'd5, 5'd7, 5'd9, 1'b1, 32'h5555_FFFF, 32'h0, 32'h0, 3'b001, 3'b000, 1'b1, 6'd0};
    vecs[3]  = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7,
                 5'd5, 5'd7, 5'd9, 1'b1, 32'h5555_FFFF, 32'h0, 32'h0, 3'b001, 3'b010, 1'b0, 6'd1};
    vecs[4]  = '{1'b0, 2'b01, 5'd7, 5'd0, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0,
                 5'd5, 5'd9, 5'd0, 1'b1, 32'h5555_FFFF, 32'h0, 32'h0, 3'b001, 3'b000, 1'b0, 6'd1};
    vecs[5]  = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd9,
                 5'd7, 5'd9, 5'd0, 1'b1, 32'h1234, 32'h0, 32'h0, 3'b000, 3'b000, 1'b1, 6'd0};
    vecs[6]  = '{1'b0, 2'b10, 5'd0, 5'd9, 32'h0, 32'h99, 1'b0, 1'b1, 1'b1, 5'd9,
                 5'd7, 5'd5, 5'd0, 1'b1, 32'h1234, 32'h5555_FFFF, 32'h0, 3'b010, 3'b000, 1'b0, 6'd1};
    vecs[7]  = '{1'b0, 2'b01, 5'd3, 5'd0, 32'h33, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3,
                 5'd9, 5'd7, 5'd0, 1'b1, 32'h99, 32'h1234, 32'h0, 3'b001, 3'b000, 1'b1, 6'd0};
    vecs[8]  = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0,
                 5'd3, 5'd9, 5'd0, 1'b1, 32'h33, 32'h99, 32'h0, 3'b010, 3'b001, 1'b0, 6'd1};
    vecs[9]  = '{1'b0, 2'b01, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b1, 5'd0,
                 5'd0, 5'd3, 5'd0, 1'b1, 32'h0, 32'h33, 32'h0, 3'b000, 3'b010, 1'b1, 6'd1};
    vecs[10] = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0,
                 5'd0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 1'b1, 6'd1};
    vecs[11] = '{1'b0, 2'b10, 5'd0, 5'd3, 32'h0, 32'h3333, 1'b0, 1'b1, 1'b0, 5'd0,
                 5'd0, 5'd5, 5'd7, 1'b1, 32'h0, 32'h5555_FFFF, 32'h1234, 3'b010, 3'b000, 1'b0, 6'd1};
    vecs[12] = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0,
                 5'd3, 5'd5, 5'd7, 1'b1, 32'h3333, 32'h5555_FFFF, 32'h1234, 3'b011, 3'b000, 1'b0, 6'd0};
    vecs[13] = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd10,
                 5'd3, 5'd5, 5'd7, 1'b1, 32'h3333, 32'h5555_FFFF, 32'h1234, 3'b011, 3'b000, 1'b1, 6'd0};
    vecs[14] = '{1'b1, 2'b01, 5'd12, 5'd0, 32'hABC, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0,
                 5'd10, 5'd3, 5'd5, 1'b1, 32'h0, 32'h3333, 32'h5555_FFFF, 3'b110, 3'b001, 1'b0, 6'd1};
    vecs[15] = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0,
                 5'd10, 5'd12, 5'd3, 1'b1, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 1'b0, 6'd0};

    idle();
    @(negedge clk);

    // Table: drive at negedge, sample pre-edge view 1 ns later, then clock it in
    for (int i = 0; i < 16; i++) begin
      rst       = vecs[i].rst;
      we        = vecs[i].we;
      waddr     = {vecs[i].wa1, vecs[i].wa0};
      wdata     = {vecs[i].wd1, vecs[i].wd0};
      wtag      = {vecs[i].wt1, vecs[i].wt0};
      rsv_valid = vecs[i].rv;
      rsv_addr  = vecs[i].ra;
      raddr     = {vecs[i].r2, vecs[i].r1, vecs[i].r0};
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d rdata0", i), rdata[31:0], vecs[i].e0);
        check($sformatf("v%0d rdata1", i), rdata[63:32], vecs[i].e1);
        check($sformatf("v%0d rdata2", i), rdata[95:64], vecs[i].e2);
        check($sformatf("v%0d rtag", i), {29'd0, rtag}, {29'd0, vecs[i].et});
        check($sformatf("v%0d rbusy", i), {29'd0, rbusy}, {29'd0, vecs[i].eb});
        check($sformatf("v%0d rsv_ready", i), {31'd0, rsv_ready}, {31'd0, vecs[i].erdy});
        check($sformatf("v%0d busy_cnt", i), {26'd0, busy_cnt}, {26'd0, vecs[i].ecnt});
      end
      step();
    end

    // Same-cycle write to a reserved register with the read port pointed at it
    idle();
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    step();
    idle();
    we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h0000_CAFE}; wtag = 2'b01;
    raddr = {5'd0, 5'd0, 5'd4};
    #1;
`ifdef RISCV_RF_BYPASS_EN
    check("byp rdata", rdata[31:0], 32'h0000_CAFE);
    check("byp rtag", {31'd0, rtag[0]}, 32'd1);
    check("byp rbusy", {31'd0, rbusy[0]}, 32'd0);
`else
    check("byp rdata", rdata[31:0], 32'h0);
    check("byp rtag", {31'd0, rtag[0]}, 32'd0);
    check("byp rbusy", {31'd0, rbusy[0]}, 32'd1);
`endif
    check("byp cnt", {26'd0, busy_cnt}, 32'd1);
    step();
    idle();
    raddr = {5'd0, 5'd0, 5'd4};
    #1;
    check("byp next rdata", rdata[31:0], 32'h0000_CAFE);
    check("byp next rtag", {31'd0, rtag[0]}, 32'd1);
    check("byp next rbusy", {31'd0, rbusy[0]}, 32'd0);
    check("byp next cnt", {26'd0, busy_cnt}, 32'd0);
    step();

    // Colliding writes seen through read port 1
    idle();
    we = 2'b11; waddr = {5'd6, 5'd6}; wdata = {32'h22, 32'h11}; wtag = 2'b10;
    raddr = {5'd0, 5'd6, 5'd0};
    #1;
`ifdef RISCV_RF_BYPASS_EN
    check("coll byp rdata", rdata[63:32], 32'h22);
    check("coll byp rtag", {31'd0, rtag[1]}, 32'd1);
`else
    check("coll byp rdata", rdata[63:32], 32'h0);
    check("coll byp rtag", {31'd0, rtag[1]}, 32'd0);
`endif
    step();
    idle();
    raddr = {5'd0, 5'd6, 5'd0};
    #1;
    check("coll rdata", rdata[63:32], 32'h22);
    check("coll rtag", {31'd0, rtag[1]}, 32'd1);

    // FP bank: f0 is an ordinary register, x0 stays zero
    fp_we = 2'b11; fp_waddr = {6'h00, 6'h20};
    fp_wdata = {32'hFFFF_FFFF, 32'hDEAD_BEEF}; fp_wtag = 2'b11;
    fp_rsv_valid = 1'b1; fp_rsv_addr = 6'h20;
    #1;
    check("fp rsv_ready", {31'd0, fp_rsv_ready}, 32'd1);
    step();
    idle();
    fp_raddr = {6'h01, 6'h00, 6'h20};
    #1;
    check("fp f0 rdata", fp_rdata[31:0], 32'hDEAD_BEEF);
    check("fp f0 rtag", {31'd0, fp_rtag[0]}, 32'd1);
    check("fp x0 rdata", fp_rdata[63:32], 32'h0);
    check("fp x0 rtag", {31'd0, fp_rtag[1]}, 32'd0);
    check("fp rbusy", {29'd0, fp_rbusy}, 32'b001);
    check("fp cnt", {25'd0, fp_busy_cnt}, 32'd1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
